// File: rtl/csk_seq_adder.sv
// Sequential carry-skip adder/subtractor.
// Operands are captured in IDLE, then one N-bit chunk per cycle is pushed
// LSB first through a single carry-skip block. The result is presented in DONE
// until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub        operands, carry-in, 0 = add / 1 = subtract
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   s, cout, ovf          result, carry out of the MSB chunk, signed overflow

// N-bit carry-skip block: ripple sum, with the carry-out bypassed from cin
// when every bit propagates.
module csk_bloque #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum_c,
  output logic         cout_c
);

  logic [n:0]   carry_c;
  logic [n-1:0] prop_c;

  always_comb begin
    carry_c    = '0;
    sum_c      = '0;
    prop_c     = a ^ b;
    carry_c[0] = cin;
    for (int i = 0; i < int'(n); i++) begin
      sum_c[i]       = prop_c[i] ^ carry_c[i];
      carry_c[i + 1] = (a[i] & b[i]) | (prop_c[i] & carry_c[i]);
    end
    // Skip path: a fully propagating chunk passes cin straight through.
    cout_c = (&prop_c) ? cin : carry_c[n];
  end

endmodule

module csk_seq_adder #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned NCH    = W / N;
  localparam int unsigned KW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          load_c, step_c, finish_c;
  logic [W-1:0]  a_reg, b_reg;
  logic          carry;
  logic [KW-1:0] k;
  logic [N-1:0]  a_chunk_c, b_chunk_c, sum_c;
  logic          chunk_cout_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load_c    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (k == K_LAST) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current chunk always comes from the captured operands, never the ports.
  assign a_chunk_c = a_reg[32'(k) * N +: N];
  assign b_chunk_c = b_reg[32'(k) * N +: N];

  csk_bloque #(.n(N)) u_bloque (
    .a      (a_chunk_c),
    .b      (b_chunk_c),
    .cin    (carry),
    .sum_c  (sum_c),
    .cout_c (chunk_cout_c)
  );

  // Operand capture, chunk stepping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      k         <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (load_c) begin
        a_reg <= a;
        // Subtraction as a + ~b + 1: invert b and fold the +1 into the carry.
        b_reg <= sub ? ~b : b;
        carry <= cin ^ sub;
        k     <= '0;
      end else if (step_c) begin
        s[32'(k) * N +: N] <= sum_c;
        carry              <= chunk_cout_c;
        k                  <= k + KW'(1);
        if (finish_c) begin
          cout <= chunk_cout_c;
          // The MSB of the result is produced by this last chunk.
          ovf  <= (a_reg[W-1] == b_reg[W-1]) && (sum_c[N-1] != a_reg[W-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_csk_seq_adder.sv
// Self-checking bench for csk_seq_adder (W=16, N=4): directed table,
// hold/backpressure and reset-abort sequences, and random operations
// against an arithmetic reference model.
module tb_csk_seq_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned N   = 4;
  localparam int unsigned LAT = W / N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int checks;
  int errors;

  csk_seq_adder #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the two's-complement operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         v;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + (W+1)'(mcin ^ msub);
    v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub, input logic [W-1:0] es,
                        input logic ecout, input logic eovf);
    int lat;
    check({name, " ready_before"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the ports: the result must come from captured operands only.
    a = W'($urandom); b = W'($urandom); cin = ~tcin; sub = ~tsub;
    check({name, " busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1 || lat == 0) begin
        @(posedge clk);
        #1;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " s"}, 32'(s), 32'(es));
    check({name, " cout"}, 32'(cout), 32'(ecout));
    check({name, " ovf"}, 32'(ovf), 32'(eovf));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " back_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] hs;
    logic         hc, hv;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    checks = 0;
    errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};

    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset s", 32'(s), 32'd0);
    check("reset cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].s, vecs[i].cout, vecs[i].ovf);

    // Backpressure: result held, new operands refused while in DONE.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    hs = s; hc = cout; hv = ovf;
    check("hold first s", 32'(hs), 32'h2345);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("hold s", 32'(s), 32'(hs));
      check("hold cout_ovf", {30'd0, cout, ovf}, {30'd0, hc, hv});
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("hold release", {30'd0, out_valid, in_ready}, 32'b01);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
    end
    check("hold not_accepted", 32'(in_ready), 32'd1);
    check("hold retained s", 32'(s), 32'h2345);

    // Reset during the second RUN cycle aborts the operation.
    a = 16'h0FFF; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort s", 32'(s), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ~ra;
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, m[W-1:0], m[W], m[W+1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
